aes_mixcolumns_seq: RTL and testbench

AES_MIXCOLUMNS_SEQ -- requirements
Module: aes_mixcolumns_seq

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_mix_single_column.sv | 25 ++
 rtl/aes_mixcolumns_seq.sv | 104 ++++++++++
 tb/tb_aes_mixcolumns_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: field constants, MixColumns FSM states and GF(2^8) helpers.
// Pure declarations; no clocked logic and no flow control.
package aes_pkg;

    localparam int          AES_STATE_W  = 128;
    localparam int          AES_COL_W    = 32;
    localparam logic [7:0]  AES_POLY_RED = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    // xtime: multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_RED : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return gf_mul2(x) ^ x;
    endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Forward MixColumns on one 32-bit column (top byte is row 0).
// Purely combinational, zero latency; no flow control.
module aes_mix_single_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        b0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
        b1 = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
        b2 = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
        b3 = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);
        col_out = {b0, b1, b2, b3};
    end

endmodule

// File: rtl/aes_mixcolumns_seq.sv
// Sequential AES MixColumns, one column per cycle through a shared mixer; 4-cycle latency.
// Accepts only in IDLE; result holds in DONE until out_ready, giving one block per 6 cycles max.
module aes_mixcolumns_seq
    import aes_pkg::*;
#(
    parameter bit ZERO_ON_IDLE = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
);

    aes_fsm_e               fsm_q, fsm_d;
    logic [AES_STATE_W-1:0] state_q, state_d;
    logic [1:0]             col_q, col_d;
    logic                   bypass_q, bypass_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;

    logic [6:0]             col_lsb;
    logic [AES_COL_W-1:0]   col_sel;
    logic [AES_COL_W-1:0]   col_mix;

    // Column 0 lives in the top 32 bits, so the bit offset is (3 - col) * 32.
    always_comb begin
        col_lsb = {~col_q, 5'b0};
        col_sel = state_q[col_lsb +: AES_COL_W];
    end

    aes_mix_single_column u_mix (
        .col_in  (col_sel),
        .col_out (col_mix)
    );

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        col_d       = col_q;
        bypass_d    = bypass_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    fsm_d      = BUSY;
                    state_d    = in_data;
                    bypass_d   = in_bypass;
                    col_d      = 2'd0;
                    in_ready_d = 1'b0;
                end
            end
            BUSY: begin
                state_d[col_lsb +: AES_COL_W] = bypass_q ? col_sel : col_mix;
                if (col_q == 2'd3) begin
                    fsm_d       = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d       = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                fsm_d       = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            col_q       <= 2'd0;
            bypass_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            col_q       <= col_d;
            bypass_q    <= bypass_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = (ZERO_ON_IDLE && !out_valid_q) ? '0 : state_q;

endmodule

// File: tb/tb_aes_mixcolumns_seq.sv
// Directed bench for aes_mixcolumns_seq; a second instance with ZERO_ON_IDLE=1 runs in lockstep.
module tb_aes_mixcolumns_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_ready;
    logic         in_ready,   out_valid;
    logic [127:0] out_data;
    logic         in_ready_z, out_valid_z;
    logic [127:0] out_data_z;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] KC1_IN   = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
    localparam logic [127:0] KC1_OUT  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] KC2_IN   = 128'h2d26314c_c6c6c6c6_db135345_f20a225c;
    localparam logic [127:0] KC2_OUT  = 128'h4d7ebdf8_c6c6c6c6_8e4da1bc_9fdc589d;
    localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;

    always #5 clk = ~clk;

    aes_mixcolumns_seq #(.ZERO_ON_IDLE(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    aes_mixcolumns_seq #(.ZERO_ON_IDLE(1'b1)) dut_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_z),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .out_valid (out_valid_z),
        .out_ready (out_ready),
        .out_data  (out_data_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input logic [127:0] d, input logic byp,
                             input logic [127:0] exp, input string tag);
        in_valid  = 1'b1;
        in_data   = d;
        in_bypass = byp;
        tick();
        in_valid  = 1'b0;
        in_data   = ~d;
        in_bypass = ~byp;
        chk({tag, "_rdy_low"}, {127'd0, in_ready}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_vld_early"}, {127'd0, out_valid}, 128'd0);
            chk({tag, "_zoi_busy"}, out_data_z, 128'd0);
            tick();
        end
        chk({tag, "_vld"}, {127'd0, out_valid}, 128'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_zoi_data"}, out_data_z, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, {127'd0, out_valid}, 128'd0);
        chk({tag, "_rdy_back"}, {127'd0, in_ready}, 128'd1);
        chk({tag, "_zoi_idle"}, out_data_z, 128'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bypass = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_rdy", {127'd0, in_ready}, 128'd1);
        chk("rst_vld", {127'd0, out_valid}, 128'd0);
        chk("rst_data", out_data, 128'd0);
        chk("rst_zoi_data", out_data_z, 128'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rdy", {127'd0, in_ready}, 128'd1);

        run_block(FIPS_IN, 1'b0, FIPS_OUT, "fips");
        run_block(KC1_IN,  1'b0, KC1_OUT,  "kcol1");
        run_block(KC2_IN,  1'b0, KC2_OUT,  "kcol2");
        run_block(BYP_IN,  1'b1, BYP_IN,   "bypass");

        // Backpressure: hold result for 10 cycles while a new offer is pending.
        in_valid  = 1'b1;
        in_data   = KC1_IN;
        in_bypass = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_vld", {127'd0, out_valid}, 128'd1);
        in_valid  = 1'b1;
        in_data   = FIPS_IN;
        in_bypass = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_hold_vld", {127'd0, out_valid}, 128'd1);
            chk("bp_hold_data", out_data, KC1_OUT);
            chk("bp_hold_rdy", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_rel_vld", {127'd0, out_valid}, 128'd0);
        chk("bp_rel_rdy", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        chk("bp_next_accept", {127'd0, in_ready}, 128'd0);
        repeat (3) tick();
        chk("bp_next_early", {127'd0, out_valid}, 128'd0);
        tick();
        chk("bp_next_vld", {127'd0, out_valid}, 128'd1);
        chk("bp_next_data", out_data, FIPS_OUT);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset while BUSY with col == 2.
        in_valid  = 1'b1;
        in_data   = KC2_IN;
        in_bypass = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_vld", {127'd0, out_valid}, 128'd0);
        chk("mrst_rdy", {127'd0, in_ready}, 128'd1);
        chk("mrst_data", out_data, 128'd0);
        chk("mrst_zoi_data", out_data_z, 128'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mrst_no_stale_vld", {127'd0, out_valid}, 128'd0);
            chk("mrst_idle_rdy", {127'd0, in_ready}, 128'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
